// File: rtl/my9262_frame_feeder_if.sv
// my9262_frame_feeder_if: bundle between the frame feeder, its pixel RAM and the MY9262 serializer
//   master (feeder) drives : mem_rd, mem_addr, tx_data, tx_start, tx_lat_type, busy, frame_done, err_overrun
//   master (feeder) samples: frame_start, mem_rdata, tx_done
//   slave is the mirror view for the controller / RAM / serializer side
interface my9262_frame_feeder_if #(
    parameter int ADDR_W = 9
);
    logic              frame_start;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [15:0]       tx_data;
    logic              tx_start;
    logic [1:0]        tx_lat_type;
    logic              tx_done;
    logic              busy;
    logic              frame_done;
    logic              err_overrun;
    modport master (
        input  frame_start, mem_rdata, tx_done,
        output mem_rd, mem_addr, tx_data, tx_start, tx_lat_type, busy, frame_done, err_overrun
    );
    modport slave (
        output frame_start, mem_rdata, tx_done,
        input  mem_rd, mem_addr, tx_data, tx_start, tx_lat_type, busy, frame_done, err_overrun
    );
endinterface

// File: rtl/my9262_frame_feeder.sv
// my9262_frame_feeder: config + grayscale word sequencer feeding a chain of CHIP_NUM MY9262 drivers
//   CLK_200M  system clock
//   RST_N     asynchronous active-low reset
//   io_feed   master side of my9262_frame_feeder_if: frame request, pixel RAM read port,
//             serializer word handshake and status flags (all outputs registered)
module my9262_frame_feeder #(
    parameter int          CHIP_NUM    = 32,
    parameter int          CH_PER_CHIP = 16,
    parameter int          ADDR_W      = 9,
    parameter logic [15:0] CFG_WORD    = 16'h0EA0
) (
    input logic                   CLK_200M,
    input logic                   RST_N,
    my9262_frame_feeder_if.master io_feed
);
    localparam int KW = $clog2(CHIP_NUM);
    localparam int CW = CH_PER_CHIP > 1 ? $clog2(CH_PER_CHIP) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHIP_NUM - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH_PER_CHIP - 1);

    // INIT only exists so the first config word's tx_start comes from a register after reset release
    typedef enum logic [3:0] {INIT, CFG_SEND, CFG_WAIT, IDLE, RD, RDW, SEND, WAIT, DONE} state_t;

    state_t            r_state, w_nxt;
    logic [KW-1:0]     r_k, w_k;
    logic [CW-1:0]     r_ch, w_ch;
    logic              w_k_last, w_ch_last;
    logic [ADDR_W-1:0] w_addr;
    logic              r_mem_rd, r_tx_start, r_busy, r_frame_done, r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_tx_data;
    logic [1:0]        r_tx_lat;

    assign w_k_last  = r_k == K_LAST;
    assign w_ch_last = r_ch == C_LAST;
    // first word shifted ends up in the farthest chip, so chip index runs backwards
    assign w_addr    = ADDR_W'(w_ch) * ADDR_W'(CHIP_NUM) + ADDR_W'(K_LAST - w_k);

    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= INIT;
            r_k     <= '0;
            r_ch    <= '0;
        end else begin
            r_state <= w_nxt;
            r_k     <= w_k;
            r_ch    <= w_ch;
        end
    end

    always_comb begin
        w_nxt = r_state;
        w_k   = r_k;
        w_ch  = r_ch;
        case (r_state)
            INIT:     w_nxt = CFG_SEND;
            CFG_SEND: w_nxt = CFG_WAIT;
            CFG_WAIT: if (io_feed.tx_done) begin
                w_nxt = w_k_last ? IDLE : CFG_SEND;
                w_k   = w_k_last ? '0 : r_k + 1'b1;
            end
            IDLE:     w_nxt = io_feed.frame_start ? RD : IDLE;
            RD:       w_nxt = RDW;
            RDW:      w_nxt = SEND;
            SEND:     w_nxt = WAIT;
            WAIT:     if (io_feed.tx_done) begin
                w_nxt = (w_k_last && w_ch_last) ? DONE : RD;
                w_k   = w_k_last ? '0 : r_k + 1'b1;
                w_ch  = w_k_last ? (w_ch_last ? '0 : r_ch + 1'b1) : r_ch;
            end
            DONE: begin
                w_nxt = IDLE;
                w_k   = '0;
                w_ch  = '0;
            end
            default:  w_nxt = INIT;
        endcase
    end

    // outputs are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_tx_lat     <= 2'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_rd     <= w_nxt == RD;
            r_tx_start   <= w_nxt == CFG_SEND || w_nxt == SEND;
            r_busy       <= w_nxt != IDLE;
            r_frame_done <= w_nxt == DONE;
            r_err        <= r_err | (io_feed.frame_start & (r_state != IDLE));
            if (w_nxt == RD)
                r_mem_addr <= w_addr;
            if (w_nxt == CFG_SEND) begin
                r_tx_data <= CFG_WORD;
                r_tx_lat  <= w_k == K_LAST ? 2'd3 : 2'd0;
            end
            if (r_state == RDW)
                r_tx_data <= io_feed.mem_rdata;
            if (w_nxt == SEND)
                r_tx_lat <= w_k == K_LAST ? (w_ch == C_LAST ? 2'd2 : 2'd1) : 2'd0;
        end
    end

    assign io_feed.mem_rd      = r_mem_rd;
    assign io_feed.mem_addr    = r_mem_addr;
    assign io_feed.tx_data     = r_tx_data;
    assign io_feed.tx_start    = r_tx_start;
    assign io_feed.tx_lat_type = r_tx_lat;
    assign io_feed.busy        = r_busy;
    assign io_feed.frame_done  = r_frame_done;
    assign io_feed.err_overrun = r_err;
endmodule

// File: tb/tb_my9262_frame_feeder.sv
// tb_my9262_frame_feeder: randomized bench with a queue-based word-sequence model of the frame feeder
module tb_my9262_frame_feeder;
    localparam int          CHIP_NUM    = 32;
    localparam int          CH_PER_CHIP = 16;
    localparam int          ADDR_W      = 9;
    localparam int          NW          = CHIP_NUM * CH_PER_CHIP;
    localparam logic [15:0] CFG_WORD    = 16'h0EA0;

    logic CLK_200M = 1'b0;
    logic RST_N    = 1'b0;
    always #5 CLK_200M = ~CLK_200M;

    my9262_frame_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    my9262_frame_feeder #(
        .CHIP_NUM(CHIP_NUM), .CH_PER_CHIP(CH_PER_CHIP), .ADDR_W(ADDR_W), .CFG_WORD(CFG_WORD)
    ) dut (
        .CLK_200M(CLK_200M),
        .RST_N(RST_N),
        .io_feed(bus)
    );

    typedef struct {
        logic [15:0]       d;
        logic [1:0]        l;
        logic [ADDR_W-1:0] a;
        bit                cfg;
    } exp_t;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    logic [15:0] mem [NW];
    int lat_lo = 20, lat_hi = 20;
    bit inj_send = 0;
    int inj_req = 0, inj_ack = 0;

    // pixel RAM: data valid exactly in the cycle after mem_rd, garbage otherwise
    initial begin
        bit pend = 0;
        logic [ADDR_W-1:0] paddr = '0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge CLK_200M); #1;
            bus.mem_rdata = pend ? mem[paddr] : 16'($urandom);
            pend  = bus.mem_rd;
            paddr = bus.mem_addr;
        end
    end

    // serializer: answers each tx_start with a tx_done after a random latency
    initial begin
        int cd = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge CLK_200M); #1;
            bus.tx_done = 1'b0;
            if (!RST_N) cd = 0;
            else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) bus.tx_done = 1'b1;
                end else if (inj_req != inj_ack) begin
                    bus.tx_done = 1'b1;
                    inj_ack++;
                end
                if (bus.tx_start) begin
                    cd = $urandom_range(lat_hi, lat_lo);
                    if (inj_send && $urandom_range(3, 0) == 0) begin
                        bus.tx_done = 1'b1;
                        if (cd < 2) cd = 2;
                    end
                end
            end
        end
    end

    // reference model + compare, evaluated mid-cycle
    exp_t q[$];
    exp_t cur;
    bit m_idle = 0, m_err = 0, hold = 0, loaded = 0;
    int st_cnt = 0, rd_cnt = 0, fd_cnt = 0, idle_cnt = 0;
    int nwords = 0, data_started = 0, cfg_done = 0, fd_seen = 0, widx = 0;
    logic [15:0] hd;
    logic [1:0]  hl;
    logic [15:0] seen_d [NW];
    logic [1:0]  seen_l [NW];

    always @(negedge CLK_200M) begin
        if (!RST_N) begin
            chk("reset_outputs", {bus.mem_rd, bus.mem_addr, bus.tx_data, bus.tx_start, bus.tx_lat_type,
                                  bus.busy, bus.frame_done, bus.err_overrun}, 32'd0);
            q.delete();
            hold = 0; loaded = 0; m_idle = 0; m_err = 0;
            st_cnt = 0; rd_cnt = 0; fd_cnt = 0; idle_cnt = 0;
        end else begin
            if (idle_cnt > 0) begin
                idle_cnt--;
                if (idle_cnt == 0) m_idle = 1;
            end
            chk("tx_start", bus.tx_start, st_cnt == 1);
            chk("mem_rd", bus.mem_rd, rd_cnt == 1);
            chk("frame_done", bus.frame_done, fd_cnt == 1);
            chk("err_overrun", bus.err_overrun, m_err);
            if (loaded) chk("busy", bus.busy, !m_idle);
            if (st_cnt > 0) st_cnt--;
            if (rd_cnt > 0) rd_cnt--;
            if (fd_cnt > 0) fd_cnt--;
            if (bus.frame_done) fd_seen++;
            if (!loaded) begin
                for (int k = 0; k < CHIP_NUM; k++)
                    q.push_back('{d: CFG_WORD, l: (k == CHIP_NUM - 1) ? 2'd3 : 2'd0, a: '0, cfg: 1'b1});
                loaded = 1; st_cnt = 1; widx = 0; cfg_done = 0;
            end
            if (bus.mem_rd && q.size() > 0) chk("mem_addr", bus.mem_addr, q[0].a);
            if (hold && !bus.tx_start) begin
                chk("tx_data_hold", bus.tx_data, hd);
                chk("tx_lat_hold", bus.tx_lat_type, hl);
            end
            if (hold && bus.tx_done) begin
                hold = 0;
                if (cur.cfg) begin
                    cfg_done++;
                    if (q.size() == 0) idle_cnt = 1;
                    else st_cnt = 1;
                end else begin
                    nwords++;
                    if (q.size() == 0) begin
                        fd_cnt = 1; idle_cnt = 2;
                        chk("frame_word_count", nwords, NW);
                    end else begin
                        rd_cnt = 1; st_cnt = 3;
                    end
                end
            end
            if (bus.tx_start && q.size() > 0) begin
                cur = q.pop_front();
                chk("tx_data", bus.tx_data, cur.d);
                chk("tx_lat_type", bus.tx_lat_type, cur.l);
                if (widx < NW) begin
                    seen_d[widx] = bus.tx_data;
                    seen_l[widx] = bus.tx_lat_type;
                    widx++;
                end
                if (!cur.cfg) data_started++;
                hold = 1; hd = bus.tx_data; hl = bus.tx_lat_type;
            end
            if (bus.frame_start) begin
                if (m_idle) begin
                    for (int w = 0; w < NW; w++) begin
                        int k, c, a;
                        k = w % CHIP_NUM;
                        c = w / CHIP_NUM;
                        a = c * CHIP_NUM + CHIP_NUM - 1 - k;
                        q.push_back('{d: mem[a],
                                      l: (k == CHIP_NUM - 1) ? ((c == CH_PER_CHIP - 1) ? 2'd2 : 2'd1) : 2'd0,
                                      a: ADDR_W'(a), cfg: 1'b0});
                    end
                    m_idle = 0; rd_cnt = 1; st_cnt = 3; widx = 0; nwords = 0;
                end else m_err = 1;
            end
        end
    end

    task automatic tick();
        @(posedge CLK_200M); #1;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(m_idle && !bus.busy) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            checks++;
            $display("FAIL %s: idle not reached, busy=%0b", name, bus.busy);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        bus.frame_start = 1'b0;
        for (int a = 0; a < NW; a++) mem[a] = 16'(a);
        repeat (3) tick();
        #2 RST_N = 1'b1;
        repeat (50) tick();
        pulse_start();
        wait_idle("config");
        chk("cfg_count", cfg_done, CHIP_NUM);
        chk("cfg_first_word", seen_d[0], 16'h0EA0);
        chk("cfg_first_lat", seen_l[0], 0);
        chk("cfg_31_lat", seen_l[30], 0);
        chk("cfg_last_lat", seen_l[31], 3);
        chk("err_after_cfg", bus.err_overrun, 1);

        inj_req++;
        repeat (2) tick();
        inj_req++;
        repeat (3) tick();
        lat_lo = 1; lat_hi = 3;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("mem_rd_at_N+1", bus.mem_rd, 1);
        chk("first_addr", bus.mem_addr, 31);
        tick();
        chk("tx_start_not_N+2", bus.tx_start, 0);
        tick();
        chk("tx_start_at_N+3", bus.tx_start, 1);
        chk("first_data_at_N+3", bus.tx_data, 31);
        wait_idle("frame1");
        chk("f1_word1", seen_d[0], 31);
        chk("f1_word32", seen_d[31], 0);
        chk("f1_word32_lat", seen_l[31], 1);
        chk("f1_word33", seen_d[32], 63);
        chk("f1_word33_lat", seen_l[32], 0);
        chk("f1_last", seen_d[NW-1], 480);
        chk("f1_last_lat", seen_l[NW-1], 2);
        chk("f1_frame_done_once", fd_seen, 1);

        for (int a = 0; a < NW; a++) mem[a] = 16'($urandom);
        lat_lo = 1; lat_hi = 6; inj_send = 1;
        pulse_start();
        repeat (200) tick();
        pulse_start();
        wait_idle("frame2");
        chk("f2_frame_done", fd_seen, 2);
        chk("err_sticky", bus.err_overrun, 1);

        for (int a = 0; a < NW; a++) mem[a] = 16'($urandom);
        pulse_start();
        n = 0;
        while (bus.frame_done !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            checks++;
            $display("FAIL frame3: frame_done never seen");
        end
        pulse_start();
        chk("start_on_done_busy", bus.busy, 0);
        tick();
        chk("start_on_done_rd", bus.mem_rd, 0);
        wait_idle("frame3");
        chk("f3_frame_done", fd_seen, 3);

        lat_lo = 1; lat_hi = 4;
        base = data_started;
        pulse_start();
        n = 0;
        while (data_started < base + 100 && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            checks++;
            $display("FAIL reset_test: 100 data words not reached");
        end
        lat_lo = 20; lat_hi = 20;
        #2 RST_N = 1'b0;
        repeat (3) tick();
        #2 RST_N = 1'b1;
        tick();
        chk("err_cleared_by_reset", bus.err_overrun, 0);
        wait_idle("reconfig");
        chk("reconfig_count", cfg_done, CHIP_NUM);
        chk("reconfig_last_lat", seen_l[31], 3);

        lat_lo = 1; lat_hi = 2; inj_send = 0;
        for (int a = 0; a < NW; a++) mem[a] = 16'($urandom);
        pulse_start();
        wait_idle("frame_after_reset");
        chk("frame_done_total", fd_seen, 4);
        chk("err_after_reset_frame", bus.err_overrun, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
